fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_pkg
// Brief    : Shared constants and fetch FSM state encoding for the front end.
// Revision : 1.0
// ============================================================================
package fetch_ctrl_pkg;

    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0100_0000;
    localparam logic [31:0] INSN_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch FSM with redirect flushing.
// Revision : 1.0
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                 AWIDTH   = 32,
    parameter int                 DWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  RESET_PC = AWIDTH'(IMEM_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    input  logic              ready_i,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam logic [AWIDTH-1:0] c_ALIGN_MASK = ~AWIDTH'(3);
    localparam logic [AWIDTH-1:0] c_PC_STEP    = AWIDTH'(4);
    localparam logic [DWIDTH-1:0] c_NOP        = DWIDTH'(INSN_NOP);

    fetch_state_e      r_state;
    logic [AWIDTH-1:0] r_pc_q;
    logic [AWIDTH-1:0] r_req_pc;
    logic [AWIDTH-1:0] r_pc_o;
    logic [DWIDTH-1:0] r_insn;
    logic              r_valid;

    fetch_state_e      w_state_nxt;
    logic [AWIDTH-1:0] w_pc_q_nxt;
    logic [AWIDTH-1:0] w_req_pc_nxt;
    logic [AWIDTH-1:0] w_pc_o_nxt;
    logic [DWIDTH-1:0] w_insn_nxt;
    logic              w_valid_nxt;
    logic [AWIDTH-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc_i & c_ALIGN_MASK;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_q_nxt   = r_pc_q;
        w_req_pc_nxt = r_req_pc;
        w_pc_o_nxt   = r_pc_o;
        w_insn_nxt   = r_insn;
        w_valid_nxt  = r_valid;

        case (r_state)
            REQ: begin
                // A granted request under redirect still owes a response; DROP eats it.
                if (redirect_i) begin
                    w_pc_q_nxt = w_redirect_pc;
                    if (imem_gnt_i) begin
                        w_state_nxt = DROP;
                    end
                end else if (imem_gnt_i) begin
                    w_req_pc_nxt = r_pc_q;
                    w_state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    w_pc_q_nxt  = w_redirect_pc;
                    w_state_nxt = imem_rvalid_i ? REQ : DROP;
                end else if (imem_rvalid_i) begin
                    w_insn_nxt  = imem_rdata_i;
                    w_pc_o_nxt  = r_req_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_q_nxt  = r_req_pc + c_PC_STEP;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // insn_o returns to NOP whenever valid_o drops so decode never sees stale data.
                if (redirect_i) begin
                    w_valid_nxt = 1'b0;
                    w_insn_nxt  = c_NOP;
                    w_pc_q_nxt  = w_redirect_pc;
                    w_state_nxt = REQ;
                end else if (ready_i) begin
                    w_valid_nxt = 1'b0;
                    w_insn_nxt  = c_NOP;
                    w_state_nxt = REQ;
                end
            end
            DROP: begin
                if (redirect_i) begin
                    w_pc_q_nxt = w_redirect_pc;
                end
                if (imem_rvalid_i) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= REQ;
            r_pc_q   <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_pc_o   <= RESET_PC;
            r_insn   <= c_NOP;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc_q   <= w_pc_q_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_pc_o   <= w_pc_o_nxt;
            r_insn   <= w_insn_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign imem_req_o  = (r_state == REQ) && !rst;
    assign imem_addr_o = r_pc_q;
    assign valid_o     = r_valid;
    assign pc_o        = r_pc_o;
    assign insn_o      = r_insn;

endmodule : fetch_ctrl
`default_nettype wire
